// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache, one 32-bit word per line.
// Hits are served combinationally in IDLE; a miss runs a two-state fetch
// that fills the line from memory and then lets the lookup hit.
module icache #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] miss_cnt
);

  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TAG = 30 - IDX;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state;
  logic [31:0]       maddr;
  logic [SETS-1:0]   valid;
  logic [TAG-1:0]    tag_arr  [SETS];
  logic [31:0]       data_arr [SETS];

  logic [IDX-1:0]    req_idx;
  logic [TAG-1:0]    req_tag;
  logic [IDX-1:0]    fill_idx;
  logic              hit;
  logic              fill;
  logic              unused_addr_bits;

  assign req_idx  = imemaddr[IDX+1:2];
  assign req_tag  = imemaddr[31:IDX+2];
  assign fill_idx = maddr[IDX+1:2];
  assign fill     = (state == FETCH) && !iwait;
  assign iaddr    = maddr;

  // byte-offset bits of the fetch address never select anything
  assign unused_addr_bits = ^imemaddr[1:0];

  // Lookup: hit only reported while idle, so the fill cycle never bypasses iload
  always_comb begin
    hit      = imemREN && valid[req_idx] && (tag_arr[req_idx] == req_tag);
    ihit     = hit && (state == IDLE);
    imemload = ihit ? data_arr[req_idx] : 32'h0;
  end

  // Miss FSM: latch miss address, hold iREN through FETCH, set valid on fill
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      maddr    <= '0;
      miss_cnt <= '0;
      valid    <= '0;
      iREN     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !hit) begin
            maddr    <= {imemaddr[31:2], 2'b00};
            miss_cnt <= miss_cnt + 32'd1;
            iREN     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            valid[fill_idx] <= 1'b1;
            iREN            <= 1'b0;
            state           <= IDLE;
          end
        end
        default: begin
          iREN  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays: no reset needed, validity is tracked by the valid bits
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_arr[fill_idx]  <= maddr[31:IDX+2];
      data_arr[fill_idx] <= iload;
    end
  end

endmodule
